// File: rtl/instr_buffer.sv
// Instruction buffer: circular FIFO between fetch and dispatch with 4-wide sparse enqueue.
// Latency: 1 cycle from fetch_packet write to visibility on dispatch_packet; no bypass.
// Backpressure: ib_free_slots credits from registered count; oversize enqueue is dropped and flagged.

package instr_buffer_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        is_branch;
      logic        bp_pred_taken;
      logic [31:0] bp_pred_target;
      logic [7:0]  bp_ghr_snapshot;
   } fetch_packet_t;
endpackage

module instr_buffer
   import instr_buffer_pkg::*;
#(
   parameter  int IB_DEPTH       = 16,
   parameter  int DISPATCH_WIDTH = 3,
   localparam int IB_IDX_BITS    = $clog2(IB_DEPTH),
   localparam int DC_W           = $clog2(DISPATCH_WIDTH + 1)
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 flush,
   input  fetch_packet_t [3:0]                  fetch_packet,
   output logic [IB_IDX_BITS:0]                 ib_free_slots,
   output fetch_packet_t [DISPATCH_WIDTH-1:0]   dispatch_packet,
   input  logic [DC_W-1:0]                      dispatch_count,
   output logic                                 overflow_err
);

   localparam int CNT_W = IB_IDX_BITS + 1;

   typedef logic [IB_IDX_BITS-1:0] idx_t;
   typedef logic [CNT_W-1:0]       cnt_t;

   fetch_packet_t entries_q [IB_DEPTH];
   fetch_packet_t entries_d [IB_DEPTH];
   idx_t          head_q, head_d;
   idx_t          tail_q, tail_d;
   cnt_t          count_q, count_d;
   logic          overflow_err_q, overflow_err_d;

   logic [2:0]    enq_n;
   cnt_t          dc_ext;
   cnt_t          deq_avail;
   cnt_t          deq_n;
   logic          enq_viol;
   logic          deq_viol;
   idx_t          wr_off;
   idx_t          wr_idx;

   // Free-slot credit reflects only registered occupancy; a same-cycle dequeue is not credited.
   assign ib_free_slots = cnt_t'(IB_DEPTH) - count_q;
   assign overflow_err  = overflow_err_q;

   // Number of valid fetch slots this cycle (slots may be sparse).
   always_comb begin
      enq_n = '0;
      for (int s = 0; s < 4; s++) begin
         enq_n = enq_n + {2'b00, fetch_packet[s].valid};
      end
   end

   // Dequeue amount is clamped to what is both buffered and presentable; asking for more is a violation.
   always_comb begin
      dc_ext    = cnt_t'(dispatch_count);
      deq_avail = (count_q < cnt_t'(DISPATCH_WIDTH)) ? count_q : cnt_t'(DISPATCH_WIDTH);
      deq_viol  = (dc_ext > deq_avail);
      deq_n     = deq_viol ? deq_avail : dc_ext;
      enq_viol  = (cnt_t'(enq_n) > ib_free_slots);
   end

   // Next-state: flush wins over traffic; otherwise compact valid slots at tail and retire from head.
   always_comb begin
      entries_d      = entries_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      overflow_err_d = overflow_err_q;
      wr_off         = '0;
      wr_idx         = '0;

      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         for (int e = 0; e < IB_DEPTH; e++) begin
            entries_d[e].valid = 1'b0;
         end
      end else begin
         overflow_err_d = overflow_err_q | enq_viol | deq_viol;

         // Retired entries lose their valid bit; they never overlap the slots written below
         // because enqueue is admitted against the pre-dequeue free count.
         for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (cnt_t'(i) < deq_n) begin
               entries_d[head_q + idx_t'(i)].valid = 1'b0;
            end
         end

         if (!enq_viol) begin
            for (int s = 0; s < 4; s++) begin
               if (fetch_packet[s].valid) begin
                  wr_idx            = tail_q + wr_off;
                  entries_d[wr_idx] = fetch_packet[s];
                  wr_off            = wr_off + idx_t'(1);
               end
            end
            tail_d  = tail_q + idx_t'(enq_n);
            count_d = count_q + cnt_t'(enq_n) - deq_n;
         end else begin
            count_d = count_q - deq_n;
         end

         head_d = head_q + deq_n[IB_IDX_BITS-1:0];
      end
   end

   // Dispatch lanes show the oldest entries; lanes beyond occupancy are all-zero.
   always_comb begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         dispatch_packet[i] = '0;
         if (cnt_t'(i) < count_q) begin
            dispatch_packet[i]       = entries_q[head_q + idx_t'(i)];
            dispatch_packet[i].valid = 1'b1;
         end
      end
   end

   // State registers; reset discards everything including the sticky error.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         overflow_err_q <= 1'b0;
         for (int e = 0; e < IB_DEPTH; e++) begin
            entries_q[e].valid <= 1'b0;
         end
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         overflow_err_q <= overflow_err_d;
         entries_q      <= entries_d;
      end
   end

endmodule

// File: doc/instr_buffer.md
INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 SHALL have parameter IB_DEPTH, default 16: entry count, power of two, at least 8.
REQ-002 SHALL have parameter DISPATCH_WIDTH, default 3: maximum entries presented to dispatch per cycle, 1..4.
REQ-003 SHALL have localparam IB_IDX_BITS, equal to log2(IB_DEPTH).
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  mispredict recovery; driven from correct_branch_target.valid.
REQ-007 SHALL have port fetch_packet  input  FETCH_PACKET[3:0]  fetch slots, each with its own valid bit; valid bits may be sparse.
REQ-008 SHALL have port ib_free_slots  output  [IB_IDX_BITS:0]  free entries, equal to IB_DEPTH - count.
REQ-009 SHALL have port dispatch_packet  output  FETCH_PACKET[DISPATCH_WIDTH-1:0]  oldest entries, in program order.
REQ-010 SHALL have port dispatch_count  input  [$clog2(DISPATCH_WIDTH+1)-1:0]  number of entries dispatch consumes this cycle.
REQ-011 SHALL have port overflow_err  output  1  sticky error flag, set on an enqueue or dequeue protocol violation.

Function
REQ-012 SHALL be a circular FIFO with registered head, tail and count; head and tail wrap modulo IB_DEPTH; count ranges 0..IB_DEPTH.
REQ-013 SHALL drive ib_free_slots combinationally from registered count only; same-cycle dequeue SHALL NOT be credited.
REQ-014 SHALL compute enq_n = popcount of fetch_packet[3:0].valid.
REQ-015 SHALL compact valid slots in ascending index order and write them to tail, tail+1, ..., tail+enq_n-1 (mod IB_DEPTH); entry fields SHALL be stored unmodified (pc, inst, is_branch, bp_pred_taken, bp_pred_target, bp_ghr_snapshot).
REQ-016 SHALL, if enq_n > ib_free_slots, write nothing, leave tail unchanged and set overflow_err.
REQ-017 SHALL drive dispatch_packet[i] from entry (head+i) mod IB_DEPTH; valid SHALL be 1 iff i < count; all fields of invalid lanes SHALL be 0.
REQ-018 SHALL give an enqueued entry latency of exactly 1 cycle: written at edge N, visible on dispatch_packet after edge N; no fetch-to-dispatch bypass.
REQ-019 SHALL dequeue deq_n = min(dispatch_count, count, DISPATCH_WIDTH) entries; if dispatch_count > min(count, DISPATCH_WIDTH), it SHALL dequeue only that minimum and set overflow_err.
REQ-020 SHALL update on a simultaneous enqueue and dequeue as count_next = count + enq_accepted - deq_n, head_next = head + deq_n, tail_next = tail + enq_accepted; full-to-full and empty-with-enqueue SHALL be legal in the same cycle.
REQ-021 SHALL, when flush = 1, set head, tail and count to 0 at the next edge, clear all entry valid bits, and ignore enqueue and dequeue in that cycle; overflow_err SHALL be unaffected.
REQ-022 SHALL, when count = IB_DEPTH, drive ib_free_slots = 0; a packet with enq_n = 0 in that state is legal and SHALL NOT set the error.
REQ-023 SHALL hold no other state: no FSM beyond the FIFO pointers and the sticky error flag.

Reset
REQ-024 SHALL, when reset is high at an edge, set head, tail and count to 0, clear all entry valid bits, and clear overflow_err.
REQ-025 SHALL, after reset, drive ib_free_slots = IB_DEPTH and all dispatch_packet valid bits = 0.
REQ-026 SHALL give reset priority over flush, enqueue and dequeue.
REQ-027 SHALL, on reset asserted mid-operation, discard all buffered entries with no partial dequeue.

Verification
REQ-028 SHALL cover: reset, then fetch_packet valid = 4'b1010 (pc 0x104, 0x10C) with dispatch_count = 0 -> next cycle dispatch_packet[0].pc = 0x104 and [1].pc = 0x10C, both valid; [2] invalid; ib_free_slots = 14.
REQ-029 SHALL cover: fill to count = 14, then enqueue 4 -> no write, count stays 14, overflow_err = 1.
REQ-030 SHALL cover: count = 16 (full), enqueue 3 and dispatch_count = 3 in the same cycle -> enqueue rejected (free = 0) with error; count = 13 after the edge.
REQ-031 SHALL cover: wrap-around, with head = 14, count = 2 and an enqueue of 4 -> writes go to entries 0..3; dispatch order is pcs of entries 14, 15, 0 in lanes 0..2.
REQ-032 SHALL cover: count = 9, flush together with enqueue 4 and dispatch_count = 3 -> next cycle count = 0, ib_free_slots = 16, no lane valid.
REQ-033 SHALL cover: count = 1, dispatch_count = 3 -> 1 entry dequeued, count = 0, overflow_err = 1; a subsequent reset clears overflow_err to 0.
